// File: rtl/stq_drain.sv
// stq_drain: drains passe (retired) store-queue entries in program order into
// the two L1D write lanes, with a skid stage for cache back-pressure and a
// freed-index return path to the allocator.
module stq_drain #(
    parameter int unsigned ADATA_W = 64,
    parameter int unsigned DATA_W  = 136
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               pse0_en,
    input  logic [5:0]         pse0_WQ,
    input  logic               pse1_en,
    input  logic [5:0]         pse1_WQ,

    output logic               rd0_en,
    output logic [5:0]         rd0_WQ,
    output logic               rd1_en,
    output logic [5:0]         rd1_WQ,
    input  logic [DATA_W-1:0]  rd0_data,
    input  logic [DATA_W-1:0]  rd1_data,
    input  logic [31:0]        rd0_bnkEn,
    input  logic [31:0]        rd1_bnkEn,
    input  logic [ADATA_W-1:0] rd0_adata,
    input  logic [ADATA_W-1:0] rd1_adata,

    output logic               wb0_en,
    output logic [5:0]         wb0_LSQ,
    output logic [ADATA_W-1:0] wb0_adata,
    output logic [DATA_W-1:0]  wb0_data,
    output logic [31:0]        wb0_bnkEn,
    output logic               wb1_en,
    output logic [5:0]         wb1_LSQ,
    output logic [ADATA_W-1:0] wb1_adata,
    output logic [DATA_W-1:0]  wb1_data,
    output logic [31:0]        wb1_bnkEn,
    input  logic               wb_stall,

    output logic [63:0]        free_en,
    output logic [1:0]         free_cnt,
    output logic               drain_idle
);

    localparam int unsigned IDX_W = 6;
    localparam int unsigned NENT  = 64;
    localparam int unsigned BNK_W = 32;

    // One write-lane payload as it moves through S1, skid and wb.
    typedef struct packed {
        logic               v;
        logic [IDX_W-1:0]   wq;
        logic [ADATA_W-1:0] adata;
        logic [DATA_W-1:0]  data;
        logic [BNK_W-1:0]   bnk;
    } lane_t;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [NENT-1:0]  r_passe;
    logic [IDX_W-1:0] r_rd_ptr;
    logic [IDX_W-1:0] r_head;
    logic             r_inf0;
    logic             r_inf1;
    logic [IDX_W-1:0] r_inf0_wq;
    logic [IDX_W-1:0] r_inf1_wq;
    lane_t            r_sk0;
    lane_t            r_sk1;
    lane_t            r_wb0;
    lane_t            r_wb1;
    logic [NENT-1:0]  r_free_en;
    logic [1:0]       r_free_cnt;

    // ---------------------------------------------------------------------
    // Combinational
    // ---------------------------------------------------------------------
    logic             w_conflict;
    logic [IDX_W-1:0] w_rd_ptr1;
    logic             w_rd0;
    logic             w_rd1;
    logic [IDX_W-1:0] w_rd_ptr_nxt;
    lane_t            w_s1_0;
    lane_t            w_s1_1;
    logic             w_accept;
    logic             w_wb_load;
    logic [1:0]       w_acc_cnt;
    logic [NENT-1:0]  w_clr;
    logic [NENT-1:0]  w_set;
    logic [NENT-1:0]  w_passe_nxt;
    lane_t            w_wb0_nxt;
    lane_t            w_wb1_nxt;
    lane_t            w_sk0_nxt;
    lane_t            w_sk1_nxt;

    // S1 bank check: both lanes back and touching a common bank.
    assign w_conflict = r_inf0 & r_inf1 & (|(rd0_bnkEn & rd1_bnkEn));

    // S0 read issue; blocked by stall, a pending skid, or an S1 conflict.
    assign w_rd_ptr1 = r_rd_ptr + IDX_W'(1);
    assign w_rd0     = r_passe[r_rd_ptr] & ~wb_stall & ~r_sk0.v & ~w_conflict;
    assign w_rd1     = w_rd0 & r_passe[w_rd_ptr1];

    // A conflict rewinds the read pointer to the dropped lane 1 entry.
    assign w_rd_ptr_nxt = w_conflict ? r_inf1_wq
                                     : r_rd_ptr + IDX_W'(w_rd0) + IDX_W'(w_rd1);

    // Acceptance of the wb registers by the cache.
    assign w_accept  = r_wb0.v & ~wb_stall;
    assign w_wb_load = ~r_wb0.v | w_accept;
    assign w_acc_cnt = {1'b0, w_accept} + {1'b0, w_accept & r_wb1.v};

    // Assemble S1 lanes from returning read data; idle lanes are zeroed.
    always_comb begin
        w_s1_0 = '0;
        w_s1_1 = '0;
        if (r_inf0) begin
            w_s1_0.v     = 1'b1;
            w_s1_0.wq    = r_inf0_wq;
            w_s1_0.adata = rd0_adata;
            w_s1_0.data  = rd0_data;
            w_s1_0.bnk   = rd0_bnkEn;
        end
        if (r_inf1 & ~w_conflict) begin
            w_s1_1.v     = 1'b1;
            w_s1_1.wq    = r_inf1_wq;
            w_s1_1.adata = rd1_adata;
            w_s1_1.data  = rd1_data;
            w_s1_1.bnk   = rd1_bnkEn;
        end
    end

    // Passe set/clear masks; a same-cycle set on a cleared index wins.
    always_comb begin
        w_clr = '0;
        w_set = '0;
        if (w_accept) begin
            w_clr[r_wb0.wq] = 1'b1;
            if (r_wb1.v) begin
                w_clr[r_wb1.wq] = 1'b1;
            end
        end
        if (pse0_en) begin
            w_set[pse0_WQ] = 1'b1;
        end
        if (pse1_en) begin
            w_set[pse1_WQ] = 1'b1;
        end
        w_passe_nxt = (r_passe & ~w_clr) | w_set;
    end

    // Wb/skid steering: wb refills from skid first, then S1; otherwise S1 parks in skid.
    always_comb begin
        w_wb0_nxt = r_wb0;
        w_wb1_nxt = r_wb1;
        w_sk0_nxt = r_sk0;
        w_sk1_nxt = r_sk1;
        if (w_wb_load) begin
            if (r_sk0.v) begin
                w_wb0_nxt = r_sk0;
                w_wb1_nxt = r_sk1;
                w_sk0_nxt = '0;
                w_sk1_nxt = '0;
            end else begin
                w_wb0_nxt = w_s1_0;
                w_wb1_nxt = w_s1_1;
            end
        end else if (w_s1_0.v) begin
            w_sk0_nxt = w_s1_0;
            w_sk1_nxt = w_s1_1;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_passe    <= '0;
            r_rd_ptr   <= '0;
            r_head     <= '0;
            r_inf0     <= 1'b0;
            r_inf1     <= 1'b0;
            r_inf0_wq  <= '0;
            r_inf1_wq  <= '0;
            r_sk0      <= '0;
            r_sk1      <= '0;
            r_wb0      <= '0;
            r_wb1      <= '0;
            r_free_en  <= '0;
            r_free_cnt <= '0;
        end else begin
            r_passe    <= w_passe_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_head     <= r_head + IDX_W'(w_acc_cnt);
            r_inf0     <= w_rd0;
            r_inf1     <= w_rd1;
            r_inf0_wq  <= r_rd_ptr;
            r_inf1_wq  <= w_rd_ptr1;
            r_sk0      <= w_sk0_nxt;
            r_sk1      <= w_sk1_nxt;
            r_wb0      <= w_wb0_nxt;
            r_wb1      <= w_wb1_nxt;
            r_free_en  <= w_clr;
            r_free_cnt <= w_acc_cnt;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign rd0_en    = w_rd0;
    assign rd0_WQ    = r_rd_ptr;
    assign rd1_en    = w_rd1;
    assign rd1_WQ    = w_rd_ptr1;

    assign wb0_en    = r_wb0.v;
    assign wb0_LSQ   = r_wb0.wq;
    assign wb0_adata = r_wb0.adata;
    assign wb0_data  = r_wb0.data;
    assign wb0_bnkEn = r_wb0.bnk;
    assign wb1_en    = r_wb1.v;
    assign wb1_LSQ   = r_wb1.wq;
    assign wb1_adata = r_wb1.adata;
    assign wb1_data  = r_wb1.data;
    assign wb1_bnkEn = r_wb1.bnk;

    assign free_en   = r_free_en;
    assign free_cnt  = r_free_cnt;

    assign drain_idle = ~(|r_passe) & ~r_inf0 & ~r_inf1 & ~r_sk0.v & ~r_wb0.v;

endmodule

// File: tb/tb_stq_drain.sv
// tb_stq_drain: scoreboard bench for stq_drain with a behavioural store-queue model.
module tb_stq_drain;

    localparam int unsigned ADATA_W = 64;
    localparam int unsigned DATA_W  = 136;
    localparam int unsigned CW      = 192;

    typedef struct {
        logic [5:0]         wq;
        logic [DATA_W-1:0]  data;
        logic [ADATA_W-1:0] adata;
        logic [31:0]        bnk;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               pse0_en, pse1_en;
    logic [5:0]         pse0_WQ, pse1_WQ;
    logic               rd0_en, rd1_en;
    logic [5:0]         rd0_WQ, rd1_WQ;
    logic [DATA_W-1:0]  rd0_data, rd1_data;
    logic [31:0]        rd0_bnkEn, rd1_bnkEn;
    logic [ADATA_W-1:0] rd0_adata, rd1_adata;
    logic               wb0_en, wb1_en;
    logic [5:0]         wb0_LSQ, wb1_LSQ;
    logic [ADATA_W-1:0] wb0_adata, wb1_adata;
    logic [DATA_W-1:0]  wb0_data, wb1_data;
    logic [31:0]        wb0_bnkEn, wb1_bnkEn;
    logic               wb_stall;
    logic [63:0]        free_en;
    logic [1:0]         free_cnt;
    logic               drain_idle;

    stq_drain #(.ADATA_W(ADATA_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .pse0_en(pse0_en), .pse0_WQ(pse0_WQ), .pse1_en(pse1_en), .pse1_WQ(pse1_WQ),
        .rd0_en(rd0_en), .rd0_WQ(rd0_WQ), .rd1_en(rd1_en), .rd1_WQ(rd1_WQ),
        .rd0_data(rd0_data), .rd1_data(rd1_data),
        .rd0_bnkEn(rd0_bnkEn), .rd1_bnkEn(rd1_bnkEn),
        .rd0_adata(rd0_adata), .rd1_adata(rd1_adata),
        .wb0_en(wb0_en), .wb0_LSQ(wb0_LSQ), .wb0_adata(wb0_adata), .wb0_data(wb0_data), .wb0_bnkEn(wb0_bnkEn),
        .wb1_en(wb1_en), .wb1_LSQ(wb1_LSQ), .wb1_adata(wb1_adata), .wb1_data(wb1_data), .wb1_bnkEn(wb1_bnkEn),
        .wb_stall(wb_stall),
        .free_en(free_en), .free_cnt(free_cnt), .drain_idle(drain_idle)
    );

    always #5 clk = ~clk;

    // Store-queue contents and scoreboard.
    logic [DATA_W-1:0]  mem_data  [64];
    logic [ADATA_W-1:0] mem_adata [64];
    logic [31:0]        mem_bnk   [64];
    exp_t               q[$];

    int n_chk = 0;
    int n_err = 0;
    int cyc_n = 0;

    logic       cap0, cap1;
    logic [5:0] cap0_wq, cap1_wq;
    logic [63:0] exp_free;
    logic [1:0]  exp_fcnt;
    logic        prev_idle;
    int          idle_rise;
    int          wb0_cnt, wb1_cnt;

    int         rd0_cnt [64];
    int         rd0_cyc [64];
    int         acc_cyc [64];
    int         acc_lane[64];
    int         free_cyc[64];
    int         free_tally[64];
    logic       rd1_seen[64];
    logic [5:0] rd1_of  [64];

    task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[DATA_W-1:0];
    endfunction

    function automatic logic [ADATA_W-1:0] rnd_adata();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[ADATA_W-1:0];
    endfunction

    // Check one write lane against an expected entry.
    task automatic chk_lane(input int lane, input exp_t e);
        if (lane == 0) begin
            chk("wb0_LSQ",   CW'(wb0_LSQ),   CW'(e.wq));
            chk("wb0_data",  CW'(wb0_data),  CW'(e.data));
            chk("wb0_adata", CW'(wb0_adata), CW'(e.adata));
            chk("wb0_bnkEn", CW'(wb0_bnkEn), CW'(e.bnk));
        end else begin
            chk("wb1_LSQ",   CW'(wb1_LSQ),   CW'(e.wq));
            chk("wb1_data",  CW'(wb1_data),  CW'(e.data));
            chk("wb1_adata", CW'(wb1_adata), CW'(e.adata));
            chk("wb1_bnkEn", CW'(wb1_bnkEn), CW'(e.bnk));
        end
    endtask

    // Per-cycle monitor, run mid-cycle.
    task automatic mon();
        exp_t        e;
        logic [63:0] nf;
        logic [1:0]  nc;
        nf = '0;
        nc = '0;
        cap0 = rd0_en; cap0_wq = rd0_WQ;
        cap1 = rd1_en; cap1_wq = rd1_WQ;
        if (rd1_en && !rd0_en) chk("rd1_alone", CW'(rd1_en), CW'(0));
        if (rd0_en) begin
            rd0_cnt[rd0_WQ]++;
            rd0_cyc[rd0_WQ]  = cyc_n;
            rd1_seen[rd0_WQ] = rd1_en;
            rd1_of[rd0_WQ]   = rd1_WQ;
        end
        if (free_en != '0 || exp_free != '0) begin
            chk("free_en",  CW'(free_en),  CW'(exp_free));
            chk("free_cnt", CW'(free_cnt), CW'(exp_fcnt));
        end
        for (int i = 0; i < 64; i++) begin
            if (free_en[i]) begin
                free_tally[i]++;
                free_cyc[i] = cyc_n;
            end
        end
        if (drain_idle && !prev_idle) idle_rise = cyc_n;
        prev_idle = drain_idle;
        if (wb1_en && !wb0_en) chk("wb1_alone", CW'(wb1_en), CW'(0));
        if (wb0_en) begin
            wb0_cnt++;
            if (q.size() == 0) begin
                chk("wb0_unexpected", CW'(wb0_en), CW'(0));
            end else begin
                e = q[0];
                chk_lane(0, e);
                if (!wb_stall) begin
                    void'(q.pop_front());
                    acc_cyc[e.wq] = cyc_n; acc_lane[e.wq] = 0;
                    nf[e.wq] = 1'b1; nc = nc + 2'd1;
                end
                if (wb1_en) begin
                    if (q.size() < (wb_stall ? 2 : 1)) begin
                        chk("wb1_unexpected", CW'(wb1_en), CW'(0));
                    end else begin
                        e = wb_stall ? q[1] : q[0];
                        chk_lane(1, e);
                        if (!wb_stall) begin
                            void'(q.pop_front());
                            acc_cyc[e.wq] = cyc_n; acc_lane[e.wq] = 1;
                            nf[e.wq] = 1'b1; nc = nc + 2'd1;
                        end
                    end
                end
            end
        end
        if (wb1_en) wb1_cnt++;
        exp_free = nf;
        exp_fcnt = nc;
    endtask

    // One clock: monitor mid-cycle, then drive the next cycle just after the edge.
    task automatic cyc();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
        cyc_n++;
        pse0_en = 1'b0;
        pse1_en = 1'b0;
        rd0_data  = cap0 ? mem_data[cap0_wq]  : rnd_data();
        rd0_adata = cap0 ? mem_adata[cap0_wq] : rnd_adata();
        rd0_bnkEn = cap0 ? mem_bnk[cap0_wq]   : $urandom();
        rd1_data  = cap1 ? mem_data[cap1_wq]  : rnd_data();
        rd1_adata = cap1 ? mem_adata[cap1_wq] : rnd_adata();
        rd1_bnkEn = cap1 ? mem_bnk[cap1_wq]   : $urandom();
    endtask

    // Mark an entry passe in the current cycle and push its expected write.
    task automatic put(input int lane, input logic [5:0] wq, input logic [31:0] bnk);
        exp_t e;
        e.wq = wq; e.data = rnd_data(); e.adata = rnd_adata(); e.bnk = bnk;
        mem_data[wq] = e.data; mem_adata[wq] = e.adata; mem_bnk[wq] = bnk;
        q.push_back(e);
        if (lane == 0) begin pse0_en = 1'b1; pse0_WQ = wq; end
        else           begin pse1_en = 1'b1; pse1_WQ = wq; end
    endtask

    task automatic wait_drain(input int max);
        int k;
        k = 0;
        while (!(q.size() == 0 && drain_idle) && k < max) begin
            cyc();
            k++;
        end
        chk("drain_done", CW'(q.size() == 0 && drain_idle), CW'(1));
        cyc();
        cyc();
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_wb0_en"},   CW'(wb0_en),     CW'(0));
        chk({tag, "_wb1_en"},   CW'(wb1_en),     CW'(0));
        chk({tag, "_rd0_en"},   CW'(rd0_en),     CW'(0));
        chk({tag, "_rd1_en"},   CW'(rd1_en),     CW'(0));
        chk({tag, "_free_en"},  CW'(free_en),    CW'(0));
        chk({tag, "_free_cnt"}, CW'(free_cnt),   CW'(0));
        chk({tag, "_idle"},     CW'(drain_idle), CW'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc_n);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, w1, w0;
        for (int i = 0; i < 64; i++) begin
            rd0_cnt[i] = 0; rd0_cyc[i] = -1; acc_cyc[i] = -1; acc_lane[i] = -1;
            free_cyc[i] = -1; free_tally[i] = 0; rd1_seen[i] = 1'b0; rd1_of[i] = '0;
            mem_data[i] = '0; mem_adata[i] = '0; mem_bnk[i] = '0;
        end
        rst = 1'b1; wb_stall = 1'b0;
        pse0_en = 1'b0; pse1_en = 1'b0; pse0_WQ = '0; pse1_WQ = '0;
        rd0_data = '0; rd1_data = '0; rd0_adata = '0; rd1_adata = '0;
        rd0_bnkEn = '0; rd1_bnkEn = '0;
        cap0 = 1'b0; cap1 = 1'b0; cap0_wq = '0; cap1_wq = '0;
        exp_free = '0; exp_fcnt = '0; prev_idle = 1'b1; idle_rise = -1;
        wb0_cnt = 0; wb1_cnt = 0;

        cyc(); cyc(); cyc();
        chk_quiet("reset");
        rst = 1'b0;
        cyc();

        // Dual, disjoint banks: entries 0 and 1 leave together.
        t = cyc_n; w1 = wb1_cnt;
        put(0, 6'd0, 32'h3); put(1, 6'd1, 32'hC);
        cyc();
        wait_drain(50);
        chk("dual_acc0_cyc", CW'(acc_cyc[0]), CW'(t + 3));
        chk("dual_acc1_cyc", CW'(acc_cyc[1]), CW'(t + 3));
        chk("dual_lane1",    CW'(acc_lane[1]), CW'(1));
        chk("dual_wb1_cnt",  CW'(wb1_cnt - w1), CW'(1));
        chk("dual_free_cyc", CW'(free_cyc[1]), CW'(t + 4));

        // Bank conflict: entry 3 dropped, re-read as lane 0, written alone.
        t = cyc_n; w1 = wb1_cnt;
        put(0, 6'd2, 32'h10); put(1, 6'd3, 32'h10);
        cyc();
        wait_drain(50);
        chk("cfl_acc2_cyc", CW'(acc_cyc[2]), CW'(t + 3));
        chk("cfl_acc3_cyc", CW'(acc_cyc[3]), CW'(t + 5));
        chk("cfl_lane3",    CW'(acc_lane[3]), CW'(0));
        chk("cfl_rd0_3",    CW'(rd0_cnt[3]), CW'(1));
        chk("cfl_rd0_3cyc", CW'(rd0_cyc[3]), CW'(t + 3));
        chk("cfl_no_wb1",   CW'(wb1_cnt - w1), CW'(0));

        // Single store: entry 4 to reach entry 5 in order, then timed entry 5.
        put(0, 6'd4, 32'hF0);
        cyc();
        wait_drain(50);
        t = cyc_n;
        put(0, 6'd5, 32'h0000000F);
        cyc();
        wait_drain(50);
        chk("single_rd_cyc",   CW'(rd0_cyc[5]),  CW'(t + 1));
        chk("single_wb_cyc",   CW'(acc_cyc[5]),  CW'(t + 3));
        chk("single_free_cyc", CW'(free_cyc[5]), CW'(t + 4));
        chk("single_idle_cyc", CW'(idle_rise),   CW'(t + 4));

        // Stall with skid: entries 6..11, stall for three cycles with reads in flight.
        t = cyc_n;
        put(0, 6'd6, 32'h1 << 6);  put(1, 6'd7, 32'h1 << 7);  cyc();
        put(0, 6'd8, 32'h1 << 8);  put(1, 6'd9, 32'h1 << 9);  cyc();
        put(0, 6'd10, 32'h1 << 10); put(1, 6'd11, 32'h1 << 11); cyc();
        wb_stall = 1'b1;
        cyc();
        chk("stall_wb0_en",  CW'(wb0_en),  CW'(1));
        chk("stall_wb0_lsq", CW'(wb0_LSQ), CW'(6));
        chk("stall_skid_v",  CW'(dut.r_sk0.v), CW'(1));
        cyc();
        cyc();
        wb_stall = 1'b0;
        wait_drain(60);
        chk("stall_acc6_cyc",  CW'(acc_cyc[6]),  CW'(t + 6));
        chk("stall_acc8_cyc",  CW'(acc_cyc[8]),  CW'(t + 7));
        chk("stall_rd10_cyc",  CW'(rd0_cyc[10]), CW'(t + 7));
        chk("stall_acc10_cyc", CW'(acc_cyc[10]), CW'(t + 9));
        for (int i = 6; i <= 11; i++) chk("stall_freed_once", CW'(free_tally[i]), CW'(1));

        // Bulk drain 12..62 with random banks.
        for (int i = 12; i <= 62; i += 2) begin
            put(0, 6'(i), $urandom());
            if (i + 1 <= 62) put(1, 6'(i + 1), $urandom());
            cyc();
        end
        wait_drain(600);
        for (int i = 12; i <= 62; i++) chk("bulk_freed_once", CW'(free_tally[i]), CW'(1));

        // Wrap: entries 63 and 0 in one pair.
        t = cyc_n;
        put(0, 6'd63, 32'h1); put(1, 6'd0, 32'h2);
        cyc();
        wait_drain(50);
        chk("wrap_rd0_cyc",  CW'(rd0_cyc[63]),  CW'(t + 1));
        chk("wrap_rd1_seen", CW'(rd1_seen[63]), CW'(1));
        chk("wrap_rd1_wq",   CW'(rd1_of[63]),   CW'(0));
        chk("wrap_acc63",    CW'(acc_cyc[63]),  CW'(t + 3));
        chk("wrap_acc0",     CW'(acc_cyc[0]),   CW'(t + 3));
        chk("wrap_lane0",    CW'(acc_lane[0]),  CW'(1));
        chk("wrap_head",     CW'(dut.r_head),   CW'(1));

        // Reset mid-drain with wb0 valid and skid occupied.
        put(0, 6'd1, 32'h1); cyc();
        put(0, 6'd2, 32'h2); cyc();
        cyc();
        wb_stall = 1'b1;
        cyc();
        chk("rstmid_wb0_en",  CW'(wb0_en),  CW'(1));
        chk("rstmid_wb0_lsq", CW'(wb0_LSQ), CW'(1));
        chk("rstmid_skid_v",  CW'(dut.r_sk0.v), CW'(1));
        rst = 1'b1;
        cyc();
        q.delete();
        exp_free = '0;
        exp_fcnt = '0;
        rst = 1'b0;
        wb_stall = 1'b0;
        chk_quiet("rstmid");
        w0 = wb0_cnt;
        repeat (10) cyc();
        chk("rstmid_no_wb", CW'(wb0_cnt - w0), CW'(0));
        chk("rstmid_idle",  CW'(drain_idle), CW'(1));

        // Recovery after reset: pointers restart at entry 0.
        t = cyc_n;
        put(0, 6'd0, 32'h5);
        cyc();
        wait_drain(50);
        chk("post_rst_acc0", CW'(acc_cyc[0]), CW'(t + 3));
        chk("queue_empty",   CW'(q.size()),   CW'(0));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
